commit_trace_buffer: RTL
========================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port capture_en  input  1  enables recording of retired instructions.
REQ-006 SHALL have port filter_wr  input  1  when 1, record only instructions with reg_write=1.
REQ-007 SHALL have port retire_valid  input  1  an instruction retires this cycle.
REQ-008 SHALL have port prog_count  input  WORD_SIZE  PC of the retiring instruction.
REQ-009 SHALL have port instr_opcode  input  6  opcode of the retiring instruction.
REQ-010 SHALL have port reg_write  input  1  retiring instruction writes the register file.
REQ-011 SHALL have port write_reg_addr  input  5  destination register.
REQ-012 SHALL have port write_reg_data  input  WORD_SIZE  value written back.
REQ-013 SHALL have port out_valid  output  1  head entry available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-015 SHALL have port out_pc / out_opcode / out_wr_en / out_wr_addr / out_wr_data  output  WORD_SIZE/6/1/5/WORD_SIZE  head entry fields.
REQ-016 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow  output  1  sticky: a record was dropped.
REQ-018 SHALL have port drop_count  output  16  number of dropped records, saturating.
REQ-019 SHALL have port clear_status  input  1  clears overflow and drop_count.

Function
REQ-020 A record SHALL be requested in a cycle iff retire_valid & capture_en & (~filter_wr | reg_write).
REQ-021 A record SHALL hold {prog_count, instr_opcode, reg_write, write_reg_addr, write_reg_data} sampled that cycle.
REQ-022 Pop SHALL occur iff out_valid & out_ready; head advances on that edge.
REQ-023 Push SHALL be accepted iff requested and (count<DEPTH or pop in the same cycle).
REQ-024 Empty buffer with push: out_valid SHALL rise the next cycle; no same-cycle bypass (latency 1).
REQ-025 Simultaneous push and pop SHALL leave count unchanged, at any occupancy including full.
REQ-026 Requested but not accepted push SHALL set overflow and increment drop_count, saturating at 16'hFFFF.
REQ-027 out_* fields SHALL reflect the head entry whenever out_valid=1 and stay stable until popped.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count SHALL equal pushes minus pops.
REQ-029 clear_status coincident with a drop SHALL yield overflow=1, drop_count=1.
REQ-030 capture_en/filter_wr changes SHALL affect only the same-cycle request; stored entries unaffected.

Reset
REQ-031 On rst=1 at a rising edge: count=0, pointers=0, out_valid=0, overflow=0, drop_count=0; stored entries discarded.
REQ-032 rst SHALL override push, pop and clear_status in the same cycle.
REQ-033 out_pc/out_opcode/out_wr_en/out_wr_addr/out_wr_data SHALL be 0 while out_valid=0.

Verification
REQ-034 Reset, then one record {PC=0x0, op=0x00, wr_en=1, addr=8, data=0x5} with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_wr_addr=8, out_wr_data=0x5, count=1.
REQ-035 filter_wr=1, three retires with reg_write=0,1,0 (PCs 0x4,0x8,0xC) -> only PC 0x8 stored, count=1.
REQ-036 out_ready=0, 18 consecutive records -> count=16, overflow=1, drop_count=2; drain yields PCs of the first 16 in order.
REQ-037 Full buffer, push and pop same cycle -> count stays 16, new entry appended, drop_count unchanged.
REQ-038 Buffer with 5 entries and overflow=1, assert rst for one cycle -> count=0, out_valid=0, overflow=0, drop_count=0.
REQ-039 Continuous push/pop with out_ready=1 for 40 cycles -> pointer wrap, zero drops, output PC sequence equals input sequence delayed by 1 cycle.

Source files
------------

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_buffer
//  Description : FIFO trace buffer that records retired instructions
//                (PC, opcode, writeback info), with optional filtering of
//                non-writing instructions. It also keeps sticky
//                overflow/drop statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   filter_wr,
  input  logic                   retire_valid,
  input  logic [WORD_SIZE-1:0]   prog_count,
  input  logic [5:0]             instr_opcode,
  input  logic                   reg_write,
  input  logic [4:0]             write_reg_addr,
  input  logic [WORD_SIZE-1:0]   write_reg_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_pc,
  output logic [5:0]             out_opcode,
  output logic                   out_wr_en,
  output logic [4:0]             out_wr_addr,
  output logic [WORD_SIZE-1:0]   out_wr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  input  logic                   clear_status
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 2 * WORD_SIZE + 12;
  localparam logic [AW:0] C_FULL    = (AW + 1)'(DEPTH);
  localparam logic [15:0] C_DROPMAX = 16'hFFFF;

  // Record layout: {pc, opcode, wr_en, wr_addr, wr_data}
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  logic             w_req, w_pop, w_push, w_drop, w_full;
  logic [REC_W-1:0] w_rec, w_head;

  // Request/accept decode and next-state computation for pointers, occupancy, status
  always_comb begin
    w_req  = retire_valid & capture_en & (~filter_wr | reg_write);
    w_full = (count_q == C_FULL);
    w_pop  = (count_q != '0) & out_ready;
    // A full buffer still accepts a push when the head leaves on the same edge
    w_push = w_req & (~w_full | w_pop);
    w_drop = w_req & ~w_push;
    w_rec  = {prog_count, instr_opcode, reg_write, write_reg_addr, write_reg_data};

    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // A clear that coincides with a drop still records that one drop
    if (clear_status) begin
      overflow_d = w_drop;
      drop_d     = w_drop ? 16'd1 : 16'd0;
    end else begin
      overflow_d = overflow_q | w_drop;
      drop_d     = (w_drop && drop_q != C_DROPMAX) ? drop_q + 16'd1 : drop_q;
    end
  end

  // State registers; reset wins over push, pop and clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      mem_q[wr_ptr_q] <= w_rec;
    end
  end

  // Head fields are forced to zero whenever nothing is presented
  always_comb begin
    w_head    = mem_q[rd_ptr_q];
    out_valid = (count_q != '0);
    {out_pc, out_opcode, out_wr_en, out_wr_addr, out_wr_data} = out_valid ? w_head : '0;
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire
